// File: rtl/seven_seg_scan_decoder.sv
// seven_seg_scan_decoder: rebuilds the 4-digit hex number from a multiplexed 7-segment pin bus.
// Define SEVEN_SEG_SCAN_DECODER_DP_EN to add the dp_seen output (decimal point per digit).
module seven_seg_scan_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int FRAME_TIMEOUT = 1048576
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [12:1] pins,
    output logic [15:0] number,
    output logic [3:0]  digits_active,
    output logic        number_valid,
    output logic        decode_error
`ifdef SEVEN_SEG_SCAN_DECODER_DP_EN
    ,
    output logic [3:0]  dp_seen
`endif
);

    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(FRAME_TIMEOUT + 1);

    function automatic logic [4:0] decode(input logic [6:0] seg);
        case (seg)
            7'h7E:   decode = {1'b1, 4'h0};
            7'h30:   decode = {1'b1, 4'h1};
            7'h6D:   decode = {1'b1, 4'h2};
            7'h79:   decode = {1'b1, 4'h3};
            7'h33:   decode = {1'b1, 4'h4};
            7'h5B:   decode = {1'b1, 4'h5};
            7'h5F:   decode = {1'b1, 4'h6};
            7'h70:   decode = {1'b1, 4'h7};
            7'h7F:   decode = {1'b1, 4'h8};
            7'h7B:   decode = {1'b1, 4'h9};
            7'h77:   decode = {1'b1, 4'hA};
            7'h1F:   decode = {1'b1, 4'hB};
            7'h4E:   decode = {1'b1, 4'hC};
            7'h3D:   decode = {1'b1, 4'hD};
            7'h4F:   decode = {1'b1, 4'hE};
            7'h47:   decode = {1'b1, 4'hF};
            default: decode = 5'h00;
        endcase
    endfunction

    logic [12:1] sync_q, sync_d, s_q, s_d, prev_q, prev_d;
    logic [SW-1:0] stab_q, stab_d;
    logic [TW-1:0] to_q, to_d;
    logic [3:0]  seen_q, seen_d, digits_q, digits_d;
    logic [15:0] shadow_q, shadow_d, number_q, number_d;
    logic        valid_q, valid_d, err_q, err_d;
`ifdef SEVEN_SEG_SCAN_DECODER_DP_EN
    logic [3:0]  dp_sh_q, dp_sh_d, dp_seen_q, dp_seen_d;
`endif

    logic [3:0] sel;
    logic [6:0] seg;
    logic [4:0] dec;
    logic [1:0] slot;
    logic       same, capture, one_hot, single, timeout, publish;

    always_comb begin
        sync_d = pins;
        s_d = sync_q;
        prev_d = s_q;
        sel = ~{s_q[12], s_q[9], s_q[8], s_q[6]};
        seg = {s_q[11], s_q[7], s_q[4], s_q[2], s_q[1], s_q[10], s_q[5]};
        dec = decode(seg);
        slot = sel[3] ? 2'd3 : sel[2] ? 2'd2 : sel[1] ? 2'd1 : 2'd0;
        same = s_q == prev_q;
        stab_d = !same ? '0 : (stab_q == SW'(STABLE_CYCLES)) ? stab_q : stab_q + 1'b1;
        capture = same && stab_q == SW'(STABLE_CYCLES - 1);
        one_hot = sel != 4'd0 && (sel & (sel - 4'd1)) == 4'd0;
        single = capture && one_hot;
        timeout = to_q == TW'(FRAME_TIMEOUT - 1);
        // a repeated strobe closes the frame; a capture in the timeout cycle takes priority
        publish = single ? seen_q[slot] : timeout;
        valid_d = publish;
        err_d = capture && sel != 4'd0 && (!one_hot || !dec[4]);
        number_d = publish ? shadow_q : number_q;
        digits_d = publish ? seen_q : digits_q;
        to_d = (single || timeout) ? '0 : to_q + 1'b1;
        seen_d = publish ? '0 : seen_q;
        shadow_d = publish ? '0 : shadow_q;
        if (single) begin
            seen_d[slot] = 1'b1;
            shadow_d[{slot, 2'b00} +: 4] = dec[3:0];
        end
`ifdef SEVEN_SEG_SCAN_DECODER_DP_EN
        dp_seen_d = publish ? dp_sh_q : dp_seen_q;
        dp_sh_d = publish ? '0 : dp_sh_q;
        if (single) dp_sh_d[slot] = s_q[3];
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '0;
            s_q <= '0;
            prev_q <= '0;
            stab_q <= '0;
            to_q <= '0;
            seen_q <= '0;
            shadow_q <= '0;
            number_q <= '0;
            digits_q <= '0;
            valid_q <= 1'b0;
            err_q <= 1'b0;
`ifdef SEVEN_SEG_SCAN_DECODER_DP_EN
            dp_sh_q <= '0;
            dp_seen_q <= '0;
`endif
        end else begin
            sync_q <= sync_d;
            s_q <= s_d;
            prev_q <= prev_d;
            stab_q <= stab_d;
            to_q <= to_d;
            seen_q <= seen_d;
            shadow_q <= shadow_d;
            number_q <= number_d;
            digits_q <= digits_d;
            valid_q <= valid_d;
            err_q <= err_d;
`ifdef SEVEN_SEG_SCAN_DECODER_DP_EN
            dp_sh_q <= dp_sh_d;
            dp_seen_q <= dp_seen_d;
`endif
        end
    end

    assign number = number_q;
    assign digits_active = digits_q;
    assign number_valid = valid_q;
    assign decode_error = err_q;
`ifdef SEVEN_SEG_SCAN_DECODER_DP_EN
    assign dp_seen = dp_seen_q;
`endif

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// tb_seven_seg_scan_decoder: random scans against a frame-level model, scoreboarded on number_valid/decode_error.
module tb_seven_seg_scan_decoder;

    localparam int SC = 4;
    localparam int FT = 64;

    typedef struct {
        logic [15:0] num;
        logic [3:0]  dig;
        logic [3:0]  dp;
    } pub_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [12:1] pins = '0;
    logic [15:0] number;
    logic [3:0]  digits_active;
    logic        number_valid, decode_error;
`ifdef SEVEN_SEG_SCAN_DECODER_DP_EN
    logic [3:0]  dp_seen;
`endif

    int compared = 0;
    int mismatched = 0;
    pub_t pub_q[$];
    int err_pend = 0;

    logic [12:1] held = '0;
    int run = 0;
    int to_cnt = 0;
    logic [3:0] nib [4];
    logic [3:0] seen = '0;
    logic [3:0] dpm = '0;
    logic [6:0] enc [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                             7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    always #5 clock = ~clock;

    seven_seg_scan_decoder #(.STABLE_CYCLES(SC), .FRAME_TIMEOUT(FT)) dut (
        .clock(clock),
        .reset(reset),
        .pins(pins),
        .number(number),
        .digits_active(digits_active),
        .number_valid(number_valid),
        .decode_error(decode_error)
`ifdef SEVEN_SEG_SCAN_DECODER_DP_EN
        ,
        .dp_seen(dp_seen)
`endif
    );

    function automatic logic [12:1] mk(input logic [3:0] st, input logic [6:0] sg, input logic dp);
        logic [12:1] p;
        {p[11], p[7], p[4], p[2], p[1], p[10], p[5]} = sg;
        p[3] = dp;
        {p[12], p[9], p[8], p[6]} = ~st;
        return p;
    endfunction

    task automatic model_publish();
        pub_q.push_back('{num: {nib[3], nib[2], nib[1], nib[0]}, dig: seen, dp: dpm});
        seen = '0;
        dpm = '0;
        for (int i = 0; i < 4; i++) nib[i] = '0;
    endtask

    task automatic model_reset();
        pub_q.delete();
        err_pend = 0;
        held = '0;
        run = 0;
        to_cnt = 0;
        seen = '0;
        dpm = '0;
        for (int i = 0; i < 4; i++) nib[i] = '0;
    endtask

    task automatic model_capture(input logic [12:1] p, output bit single);
        logic [3:0] st;
        logic [6:0] sg;
        logic [3:0] val;
        int k;
        bit found;
        st = ~{p[12], p[9], p[8], p[6]};
        sg = {p[11], p[7], p[4], p[2], p[1], p[10], p[5]};
        single = $countones(st) == 1;
        if ($countones(st) > 1) err_pend++;
        if (single) begin
            k = 0;
            for (int i = 0; i < 4; i++) if (st[i]) k = i;
            found = 0;
            val = '0;
            for (int h = 0; h < 16; h++) if (enc[h] == sg) begin found = 1; val = 4'(h); end
            if (!found) err_pend++;
            if (seen[k]) model_publish();
            seen[k] = 1'b1;
            nib[k] = val;
            dpm[k] = p[3];
        end
    endtask

    // one call per clock: a pattern is taken once it has been held for SC+1 consecutive samples
    task automatic model_step(input logic [12:1] p);
        bit single;
        single = 0;
        if (run > 0 && p == held) run++;
        else begin held = p; run = 1; end
        if (run == SC + 1) model_capture(p, single);
        if (single) to_cnt = 0;
        else if (to_cnt + 1 == FT) begin model_publish(); to_cnt = 0; end
        else to_cnt++;
    endtask

    task automatic hold(input logic [12:1] p, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            pins = p;
            model_step(p);
        end
    endtask

    task automatic scan(input logic [15:0] v, input logic [3:0] en, input logic [3:0] dp,
                        input int len, input int bad, input bit glitch);
        logic [12:1] p;
        for (int k = 0; k < 4; k++) begin
            p = en[k] ? mk(4'(1 << k), (bad == k) ? 7'h55 : enc[v[4*k +: 4]], dp[k]) : mk(4'h0, 7'h00, 1'b0);
            if (glitch) begin
                hold(p, 2);
                hold(12'($urandom), 2);
                hold(p, len - 4);
            end else hold(p, len);
        end
    endtask

    task automatic do_reset();
        bit bad;
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            pins = 12'($urandom);
            bad = number !== 16'h0 || digits_active !== 4'h0 || number_valid !== 1'b0 || decode_error !== 1'b0;
`ifdef SEVEN_SEG_SCAN_DECODER_DP_EN
            bad = bad || dp_seen !== 4'h0;
`endif
            compared++;
            if (bad) begin
                mismatched++;
                $display("FAIL reset_state: number=%h digits=%b valid=%b err=%b, required 0000/0000/0/0",
                         number, digits_active, number_valid, decode_error);
            end
        end
        @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    always @(negedge clock) begin : monitor
        pub_t e;
        bit bad;
        if (!reset) begin
            if (number_valid) begin
                compared++;
                if (pub_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL publish: unexpected number_valid number=%h digits=%b", number, digits_active);
                end else begin
                    e = pub_q.pop_front();
                    bad = number !== e.num || digits_active !== e.dig;
`ifdef SEVEN_SEG_SCAN_DECODER_DP_EN
                    bad = bad || dp_seen !== e.dp;
`endif
                    if (bad) begin
                        mismatched++;
                        $display("FAIL publish: number=%h digits=%b, required number=%h digits=%b (dp %b)",
                                 number, digits_active, e.num, e.dig, e.dp);
                    end
                end
            end
            if (decode_error) begin
                compared++;
                if (err_pend == 0) begin
                    mismatched++;
                    $display("FAIL decode_error: pulse seen, none expected");
                end else err_pend--;
            end
        end
    end

    initial begin
        logic [15:0] v;
        logic [3:0] en, dp;
        int len, bad;
        do_reset();
        repeat (3) scan(16'h1234, 4'hF, 4'h1, 16, -1, 1'b0);
        repeat (3) scan(16'hABCD, 4'b0101, 4'h0, 16, -1, 1'b1);
        scan(16'h4321, 4'hF, 4'h0, 16, 2, 1'b0);
        repeat (2) scan(16'h4321, 4'hF, 4'h0, 16, -1, 1'b0);
        hold(mk(4'b1010, enc[5], 1'b0), 16);
        repeat (2) scan(16'h0F0F, 4'hF, 4'h0, 12, -1, 1'b0);
        hold(mk(4'h0, 7'h00, 1'b0), 200);
        repeat (40) begin
            v = 16'($urandom);
            en = 4'($urandom);
            dp = 4'($urandom);
            len = $urandom_range(6, 20);
            bad = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
            scan(v, en, dp, len, bad, $urandom_range(0, 3) == 0 && len >= 8);
            if ($urandom_range(0, 9) == 0) hold(mk(4'(3 << $urandom_range(0, 2)), enc[1], 1'b0), 10);
        end
        hold(mk(4'b0001, enc[5], 1'b0), 16);
        hold(mk(4'b0010, enc[6], 1'b0), 16);
        hold(mk(4'b0010, enc[6], 1'b0), 8);
        compared++;
        if (pub_q.size() != 0 || err_pend != 0) begin
            mismatched++;
            $display("FAIL pre_reset_drain: %0d publishes and %0d errors outstanding, required 0/0", pub_q.size(), err_pend);
        end
        do_reset();
        repeat (3) scan(16'h9ABC, 4'hF, 4'hA, 12, -1, 1'b0);
        for (int i = 0; i < 20 && (pub_q.size() != 0 || err_pend != 0); i++) hold(mk(4'h0, 7'h00, 1'b0), 1);
        compared++;
        if (pub_q.size() != 0 || err_pend != 0) begin
            mismatched++;
            $display("FAIL drain: %0d publishes and %0d errors outstanding, required 0/0", pub_q.size(), err_pend);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
